// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and default widths.
// Kept separate so the receiver can reuse the same types and constants.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int UART_DIV_WIDTH  = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// FIFO read port between the TX syn_fifo and the transmitter.
// master = the consumer that issues pops, slave = the FIFO providing data.
interface uart_tx_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_empty;
    logic                  fifo_rd_en;

    modport master (
        input  fifo_data,
        input  fifo_empty,
        output fifo_rd_en
    );

    modport slave (
        output fifo_data,
        output fifo_empty,
        input  fifo_rd_en
    );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-cycle counter: flags the last cycle of each bit period of i_div cycles.
// Held at zero while i_clr is high so every frame starts on a fresh bit.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH = UART_DIV_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clr,
    input  logic [DIV_WIDTH-1:0] i_div,
    output logic                 o_bit_end
);

    logic [DIV_WIDTH-1:0] cnt;

    // i_div is expected to be at least 1; the caller clamps a zero divisor.
    assign o_bit_end = !i_clr && (cnt == (i_div - DIV_WIDTH'(1)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (i_clr || o_bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from the TX FIFO and serialises them LSB-first
// as start + data + optional parity + 1/2 stop bits at a programmable baud.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DIV_WIDTH  = UART_DIV_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_tx_en,
    input  logic [DIV_WIDTH-1:0] i_baud_div,
    input  logic                 i_parity_en,
    input  logic                 i_parity_odd,
    input  logic                 i_stop2,
    uart_tx_if.master            fifo,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_tx_done
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    function automatic logic [DIV_WIDTH-1:0] eff_div(input logic [DIV_WIDTH-1:0] d);
        return (d == '0) ? DIV_WIDTH'(1) : d;
    endfunction

    tx_state_e             state;
    tx_state_e             state_nxt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [IDX_W-1:0]      bit_idx;
    logic                  stop_idx;
    logic [DIV_WIDTH-1:0]  div_q;
    logic                  par_en_q;
    logic                  stop2_q;
    logic                  parity_q;
    logic                  bit_end;
    logic                  last_stop;
    logic                  frame_end;
    logic                  launch;

    uart_baud_cnt #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud_cnt (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (state == IDLE),
        .i_div     (div_q),
        .o_bit_end (bit_end)
    );

    assign last_stop = !stop2_q || stop_idx;
    assign frame_end = (state == STOP) && bit_end && last_stop;
    // Gating with i_rst_n keeps the pop strobe quiet while reset is held.
    assign launch    = i_rst_n && i_tx_en && !fifo.fifo_empty &&
                       ((state == IDLE) || frame_end);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = START;
            START:   if (bit_end) state_nxt = DATA;
            DATA:    if (bit_end && (bit_idx == LAST_IDX))
                         state_nxt = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_end) state_nxt = STOP;
            STOP:    if (frame_end) state_nxt = launch ? START : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_tx = 1'b1;
        case (state)
            START:   o_tx = 1'b0;
            DATA:    o_tx = shift_reg[0];
            PARITY:  o_tx = parity_q;
            default: o_tx = 1'b1;
        endcase
        o_busy          = (state != IDLE);
        o_tx_done       = frame_end;
        fifo.fifo_rd_en = launch;
    end

    // Frame configuration is captured at the pop so mid-frame changes only
    // take effect on the next character.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_reg <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            div_q     <= '0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            parity_q  <= 1'b0;
        end else if (launch) begin
            shift_reg <= fifo.fifo_data;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            div_q     <= eff_div(i_baud_div);
            par_en_q  <= i_parity_en;
            stop2_q   <= i_stop2;
            parity_q  <= (^fifo.fifo_data) ^ i_parity_odd;
        end else if (bit_end) begin
            if (state == DATA) begin
                shift_reg <= shift_reg >> 1;
                bit_idx   <= bit_idx + IDX_W'(1);
            end
            if (state == STOP) begin
                stop_idx <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table of spec frames, hand-written corner
// sequences, and randomized frames compared with a waveform-level reference model.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int DW = 8;
    localparam int VW = 16;

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         pe;
        bit         po;
        bit         s2;
        int         exp_len;
        int         exp_par;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tx_en = 1'b0;
    logic [VW-1:0] baud_div = 16'd4;
    logic          parity_en = 1'b0;
    logic          parity_odd = 1'b0;
    logic          stop2 = 1'b0;
    logic          tx;
    logic          busy;
    logic          tx_done;

    uart_tx_if #(.DATA_WIDTH(DW)) fifo_bus ();

    uart_tx #(
        .DATA_WIDTH (DW),
        .DIV_WIDTH  (VW)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_tx_en      (tx_en),
        .i_baud_div   (baud_div),
        .i_parity_en  (parity_en),
        .i_parity_odd (parity_odd),
        .i_stop2      (stop2),
        .fifo         (fifo_bus.master),
        .o_tx         (tx),
        .o_busy       (busy),
        .o_tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    logic [7:0] fq[$];
    logic [7:0] stim_q[$];
    logic [7:0] exp_bytes[$];
    int         pops = 0;
    int         checks = 0;
    int         errors = 0;
    bit         s_tx[$], s_busy[$], s_rd[$], s_done[$];
    int         e_wave[$];

    // FIFO model: pop on the strobe, then present the new head 1 time unit later.
    always @(posedge clk) begin
        if (fifo_bus.fifo_rd_en) begin
            pops++;
            if (fq.size() > 0) void'(fq.pop_front());
        end
        #1;
        fifo_bus.fifo_empty = (fq.size() == 0);
        fifo_bus.fifo_data  = (fq.size() > 0) ? fq[0] : 8'h00;
    end

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Reference waveform: per-cycle {tx,busy,rd_en,done}, sample 0 = pop cycle.
    task automatic build_expected(input int nfr, input int div, input bit pe,
                                  input bit po, input bit s2);
        int eff;
        bit bits[$];
        eff = (div == 0) ? 1 : div;
        e_wave.delete();
        e_wave.push_back((nfr > 0) ? 4'b1010 : 4'b1000);
        for (int k = 0; k < nfr; k++) begin
            bits.delete();
            bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) bits.push_back(exp_bytes[k][i]);
            if (pe) bits.push_back((^exp_bytes[k]) ^ po);
            bits.push_back(1'b1);
            if (s2) bits.push_back(1'b1);
            for (int b = 0; b < bits.size(); b++) begin
                for (int r = 0; r < eff; r++) begin
                    bit last;
                    last = (b == bits.size() - 1) && (r == eff - 1);
                    e_wave.push_back({bits[b], 1'b1, last && (k < nfr - 1), last});
                end
            end
        end
    endtask

    task automatic run_stream(input int nfr, input int div, input bit pe, input bit po,
                              input bit s2, input int drop_at, input bit scramble,
                              input int tail);
        int pops0;
        int total;
        foreach (stim_q[i]) fq.push_back(stim_q[i]);
        stim_q.delete();
        exp_bytes = fq;
        baud_div   = VW'(div);
        parity_en  = pe;
        parity_odd = po;
        stop2      = s2;
        repeat (2) @(posedge clk);
        #2;
        pops0 = pops;
        build_expected(nfr, div, pe, po, s2);
        total = e_wave.size() + tail;
        while (e_wave.size() < total) e_wave.push_back(4'b1000);
        s_tx.delete(); s_busy.delete(); s_rd.delete(); s_done.delete();
        tx_en = 1'b1;
        for (int i = 0; i < total; i++) begin
            @(negedge clk);
            s_tx.push_back(tx);
            s_busy.push_back(busy);
            s_rd.push_back(fifo_bus.fifo_rd_en);
            s_done.push_back(tx_done);
            check("rd_on_empty", int'(fifo_bus.fifo_rd_en & fifo_bus.fifo_empty), 0);
            if (i == drop_at) tx_en = 1'b0;
            if (scramble && i == 1) begin
                baud_div   = VW'($urandom_range(0, 7));
                parity_en  = 1'($urandom_range(0, 1));
                parity_odd = 1'($urandom_range(0, 1));
                stop2      = 1'($urandom_range(0, 1));
            end
        end
        tx_en = 1'b0;
        for (int i = 0; i < total; i++) begin
            check($sformatf("wave[%0d]", i),
                  int'({s_tx[i], s_busy[i], s_rd[i], s_done[i]}), e_wave[i]);
        end
        @(posedge clk);
        #2;
        check("pop_count", pops - pops0, nfr);
    endtask

    vec_t tbl[6];
    int   seq_a5[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int len, done_at, eff, cnt;
        tbl[0] = '{8'hA5, 4, 1'b0, 1'b0, 1'b0, 40, -1};
        tbl[1] = '{8'hA5, 4, 1'b1, 1'b0, 1'b0, 44, 0};
        tbl[2] = '{8'hA5, 4, 1'b1, 1'b1, 1'b0, 44, 1};
        tbl[3] = '{8'h00, 2, 1'b0, 1'b0, 1'b1, 22, -1};
        tbl[4] = '{8'hC3, 0, 1'b1, 1'b0, 1'b1, 12, 0};
        tbl[5] = '{8'h80, 1, 1'b0, 1'b0, 1'b0, 10, -1};

        // Reset values while reset is held with enable high and FIFO empty
        tx_en = 1'b1;
        #12;
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_rd", int'(fifo_bus.fifo_rd_en), 0);
        check("rst_done", int'(tx_done), 0);
        tx_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        foreach (tbl[t]) begin
            stim_q.push_back(tbl[t].data);
            run_stream(1, tbl[t].div, tbl[t].pe, tbl[t].po, tbl[t].s2, -1, 1'b0, 3);
            eff = (tbl[t].div == 0) ? 1 : tbl[t].div;
            len = 0;
            done_at = -1;
            foreach (s_busy[i]) if (s_busy[i]) len++;
            foreach (s_done[i]) if (s_done[i]) done_at = i;
            check($sformatf("tbl%0d_len", t), len, tbl[t].exp_len);
            check($sformatf("tbl%0d_done_at", t), done_at, tbl[t].exp_len);
            if (tbl[t].exp_par >= 0)
                check($sformatf("tbl%0d_parity", t), int'(s_tx[1 + 9 * eff]), tbl[t].exp_par);
            if (t == 0)
                for (int b = 0; b < 10; b++)
                    check($sformatf("a5_bit%0d", b), int'(s_tx[1 + 4 * b]), seq_a5[b]);
            if (t == 3) begin
                cnt = 0;
                for (int i = 1; i <= 18; i++) if (!s_tx[i]) cnt++;
                check("stop2_low_run", cnt, 18);
                cnt = 0;
                for (int i = 19; i <= 22; i++) if (s_tx[i]) cnt++;
                check("stop2_high_run", cnt, 4);
            end
        end

        // Back-to-back frames: second pop on the last stop cycle, no idle gap
        stim_q.push_back(8'h55);
        stim_q.push_back(8'h0F);
        run_stream(2, 3, 1'b0, 1'b0, 1'b0, -1, 1'b0, 3);
        check("b2b_pop_at_end", int'(s_rd[30]), 1);
        check("b2b_done_at_end", int'(s_done[30]), 1);
        check("b2b_start_next", int'(s_tx[31]), 0);
        check("b2b_busy_gapless", int'(s_busy[31]), 1);

        // Enable dropped mid-frame with three queued bytes
        stim_q.push_back(8'h11);
        stim_q.push_back(8'h22);
        stim_q.push_back(8'h33);
        run_stream(1, 2, 1'b0, 1'b0, 1'b0, 5, 1'b0, 10);
        check("drop_fifo_left", fq.size(), 2);
        run_stream(2, 2, 1'b0, 1'b0, 1'b0, -1, 1'b0, 3);
        check("drop_fifo_drained", fq.size(), 0);

        // Empty FIFO: enable high but nothing to send
        run_stream(0, 3, 1'b0, 1'b0, 1'b0, -1, 1'b0, 20);

        // Asynchronous reset in the middle of the data bits
        fq.push_back(8'h00);
        baud_div = 16'd4;
        parity_en = 1'b0;
        stop2 = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        tx_en = 1'b1;
        repeat (12) @(negedge clk);
        check("mid_data_tx", int'(tx), 0);
        check("mid_data_busy", int'(busy), 1);
        tx_en = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_tx", int'(tx), 1);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_rd", int'(fifo_bus.fifo_rd_en), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stim_q.push_back(8'h96);
        run_stream(1, 4, 1'b1, 1'b1, 1'b0, -1, 1'b0, 3);

        // Randomized single frames with configuration scrambled after the pop
        for (int r = 0; r < 16; r++) begin
            stim_q.push_back(8'($urandom_range(0, 255)));
            run_stream(1, $urandom_range(0, 5), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, 1'b1, 3);
        end

        // Randomized multi-byte streams with steady configuration
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(2, 3);
            for (int k = 0; k < n; k++) stim_q.push_back(8'($urandom_range(0, 255)));
            run_stream(n, $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, 1'b0, 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
